// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci scheduler slice.
// Optional build macro used by fib_sched: FIB_SCHED_PRIO_EN.
package fib_pkg;

    localparam int unsigned FIB_W  = 11;
    localparam int unsigned FIB_NW = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/fib_core.sv
// Iterative Fibonacci engine: a/b/i/n registers with overflow tracking.
// load initialises a job, step advances one add; hit flags i == n.
module fib_core
    import fib_pkg::*;
#(
    parameter int unsigned W  = FIB_W,
    parameter int unsigned NW = FIB_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [NW-1:0] n_in,
    output logic [W-1:0]  a,
    output logic          ovf_a,
    output logic          hit
);

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [NW-1:0] i_q;
    logic [NW-1:0] n_q;
    logic          ovf_a_q;
    logic          ovf_b_q;
    logic [W:0]    sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    // ovf_x records whether the true (unbounded) value of x has reached 2^W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            n_q     <= '0;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
        end else if (load) begin
            a_q     <= '0;
            b_q     <= W'(1);
            i_q     <= '0;
            n_q     <= n_in;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
        end else if (step) begin
            a_q     <= b_q;
            b_q     <= sum[W-1:0];
            i_q     <= i_q + NW'(1);
            ovf_a_q <= ovf_b_q;
            ovf_b_q <= ovf_b_q | sum[W] | ovf_a_q;
        end
    end

    assign a     = a_q;
    assign ovf_a = ovf_a_q;
    assign hit   = (i_q == n_q);

endmodule

// File: rtl/fib_sched.sv
// Two-requester scheduler and controller for a shared fib_core engine.
// FIB_SCHED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module fib_sched
    import fib_pkg::*;
#(
    parameter int unsigned W  = FIB_W,
    parameter int unsigned NW = FIB_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [NW-1:0] n0,
    input  logic [NW-1:0] n1,
    output logic [1:0]    ack,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [W-1:0]  result,
    output logic          overflow
);

    state_t        state;
    state_t        state_nx;
    req_id_t       grant_id;
    req_id_t       job_id;
    logic          load;
    logic          step;
    logic          hit;
    logic [W-1:0]  core_a;
    logic          core_ovf;
    logic [NW-1:0] n_sel;

`ifdef FIB_SCHED_PRIO_EN
    always_comb begin
        grant_id = req[0] ? 1'b0 : 1'b1;
    end
`else
    req_id_t rr_last;

    always_comb begin
        if (req == 2'b11) grant_id = ~rr_last;
        else              grant_id = req[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rr_last <= 1'b1;
        else if (load) rr_last <= grant_id;
    end
`endif

    assign n_sel = grant_id ? n1 : n0;

    fib_core #(
        .W  (W),
        .NW (NW)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .n_in  (n_sel),
        .a     (core_a),
        .ovf_a (core_ovf),
        .hit   (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = RUN;
            RUN:     if (hit)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack  = '0;
        load = 1'b0;
        step = 1'b0;
        busy = (state != IDLE);
        done = (state == DONE);
        case (state)
            IDLE: begin
                if (|req) begin
                    ack[grant_id] = 1'b1;
                    load          = 1'b1;
                end
            end
            RUN:     step = ~hit;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_id   <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) job_id <= grant_id;
            if (state == RUN && hit) begin
                result   <= core_a;
                overflow <= core_ovf;
            end
        end
    end

    assign done_id = job_id;

endmodule

// File: tb/tb_fib_sched.sv
// Directed self-checking bench for fib_sched; expected values are hand-computed.
// Grant-order expectations follow FIB_SCHED_PRIO_EN when it is defined.
module tb_fib_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [4:0]  n0;
    logic [4:0]  n1;
    logic [1:0]  ack;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [10:0] result;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    fib_sched #(
        .W  (11),
        .NW (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .n0       (n0),
        .n1       (n1),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_done_id", 32'(done_id), 0);
        check("rst_result", 32'(result), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after an edge while IDLE with req/n already driven.
    // Done is expected to be seen in the cycle following edge n+1 after accept.
    task automatic job(input string tag, input logic [1:0] exp_ack, input int n,
                       input int exp_res, input logic exp_ovf, input logic drop);
        int cnt;
        #1;
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        @(posedge clk);
        #1;
        if (drop) req = req & ~exp_ack;
        check({tag, "_busy"}, 32'(busy), 1);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!done && ack !== 2'b00) check({tag, "_ack_busy"}, 32'(ack), 0);
        end
        check({tag, "_latency"}, 32'(cnt), 32'(n + 1));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_done_id"}, 32'(done_id), 32'(exp_ack[1]));
        check({tag, "_ack_in_done"}, 32'(ack), 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        req = 2'b00;
        n0  = '0;
        n1  = '0;

        do_reset();
        check("idle_ack", 32'(ack), 0);
        n0 = 5'd10; req = 2'b01;
        job("n10", 2'b01, 10, 55, 1'b0, 1'b1);

        do_reset();
        n0 = 5'd5; n1 = 5'd7; req = 2'b11;
        job("both_r0", 2'b01, 5, 5, 1'b0, 1'b1);
        job("both_r1", 2'b10, 7, 13, 1'b0, 1'b1);
        check("both_idle_ack", 32'(ack), 0);

        n0 = 5'd17; req = 2'b01;
        job("n17", 2'b01, 17, 1597, 1'b0, 1'b1);
        n0 = 5'd18; req = 2'b01;
        job("n18", 2'b01, 18, 536, 1'b1, 1'b1);
        n0 = 5'd20; req = 2'b01;
        job("n20", 2'b01, 20, 621, 1'b1, 1'b1);
        n0 = 5'd31; req = 2'b01;
        job("n31", 2'b01, 31, 733, 1'b1, 1'b1);
        n1 = 5'd0; req = 2'b10;
        job("n1_0", 2'b10, 0, 0, 1'b0, 1'b1);
        n1 = 5'd1; req = 2'b10;
        job("n1_1", 2'b10, 1, 1, 1'b0, 1'b1);

        // Asynchronous reset part-way through an n0=15 job.
        n0 = 5'd15; req = 2'b01;
        #1;
        check("mid_ack", 32'(ack), 1);
        @(posedge clk);
        #1;
        req = 2'b00;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_result", 32'(result), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_done_id", 32'(done_id), 0);
        check("mid_rst_ack", 32'(ack), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("mid_no_done", 32'(seen), 0);
        n1 = 5'd3; req = 2'b10;
        job("post_rst", 2'b10, 3, 2, 1'b0, 1'b1);

        // Both requesters hold req across four back-to-back jobs.
        do_reset();
        n0 = 5'd2; n1 = 5'd3; req = 2'b11;
`ifdef FIB_SCHED_PRIO_EN
        job("hold_g0", 2'b01, 2, 1, 1'b0, 1'b0);
        job("hold_g1", 2'b01, 2, 1, 1'b0, 1'b0);
        job("hold_g2", 2'b01, 2, 1, 1'b0, 1'b0);
        job("hold_g3", 2'b01, 2, 1, 1'b0, 1'b0);
`else
        job("hold_g0", 2'b01, 2, 1, 1'b0, 1'b0);
        job("hold_g1", 2'b10, 3, 2, 1'b0, 1'b0);
        job("hold_g2", 2'b01, 2, 1, 1'b0, 1'b0);
        job("hold_g3", 2'b10, 3, 2, 1'b0, 1'b0);
`endif
        req = 2'b00;
        @(posedge clk);
        #1;
        check("final_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
